// File: rtl/banyan_ingress_sched.sv
// ============================================================================
//  Module   : banyan_ingress_sched
//  Purpose  : Four-lane ingress FIFOs with rotating-priority, destination-
//             distinct head-of-line scheduling in front of a 4x4 banyan switch.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module banyan_ingress_sched #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DATA_W-1:0] in_data,
    input  logic [7:0]          in_dest,
    input  logic [3:0]          in_valid,
    output logic [3:0]          in_ready,
    output logic [4*DATA_W-1:0] sw_data,
    output logic [7:0]          sw_addr,
    output logic [3:0]          sw_valid,
    output logic [15:0]         conflict_cnt
);

    localparam int c_LANES = 4;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    // Entry layout: {dest[1:0], data[DATA_W-1:0]}
    logic [DATA_W+1:0]  r_mem      [c_LANES][DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr   [c_LANES];
    logic [c_PTR_W-1:0] r_rd_ptr   [c_LANES];
    logic [c_CNT_W-1:0] r_count    [c_LANES];
    logic [DATA_W-1:0]  r_sw_data  [c_LANES];
    logic [1:0]         r_sw_addr  [c_LANES];
    logic               r_sw_valid [c_LANES];
    logic [1:0]         r_rr;
    logic [15:0]        r_conflict_cnt;

    logic [c_LANES-1:0] w_push;
    logic [c_LANES-1:0] w_nonempty;
    logic [c_LANES-1:0] w_grant;
    logic [c_LANES-1:0] w_claimed;
    logic [1:0]         w_head_dest [c_LANES];
    logic [1:0]         w_lane;
    logic               w_any_denied;

    generate
        for (genvar g = 0; g < c_LANES; g++) begin : g_lane
            assign w_nonempty[g]  = (r_count[g] != '0);
            assign in_ready[g]    = (r_count[g] < c_CNT_W'(DEPTH)) && !rst;
            assign w_push[g]      = in_valid[g] & in_ready[g];
            assign w_head_dest[g] = r_mem[g][r_rd_ptr[g]][DATA_W +: 2];

            // Storage carries no reset; occupancy alone decides what is live.
            always_ff @(posedge clk) begin
                if (w_push[g]) begin
                    r_mem[g][r_wr_ptr[g]] <= {in_dest[2*g +: 2], in_data[g*DATA_W +: DATA_W]};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr[g]   <= '0;
                    r_rd_ptr[g]   <= '0;
                    r_count[g]    <= '0;
                    r_sw_data[g]  <= '0;
                    r_sw_addr[g]  <= '0;
                    r_sw_valid[g] <= 1'b0;
                end else begin
                    r_sw_valid[g] <= w_grant[g];
                    if (w_push[g]) begin
                        r_wr_ptr[g] <= r_wr_ptr[g] + 1'b1;
                    end
                    if (w_grant[g]) begin
                        r_rd_ptr[g]  <= r_rd_ptr[g] + 1'b1;
                        r_sw_data[g] <= r_mem[g][r_rd_ptr[g]][DATA_W-1:0];
                        r_sw_addr[g] <= w_head_dest[g];
                    end
                    case ({w_push[g], w_grant[g]})
                        2'b10:   r_count[g] <= r_count[g] + 1'b1;
                        2'b01:   r_count[g] <= r_count[g] - 1'b1;
                        default: r_count[g] <= r_count[g];
                    endcase
                end
            end

            assign sw_data[g*DATA_W +: DATA_W] = r_sw_data[g];
            assign sw_addr[2*g +: 2]           = r_sw_addr[g];
            assign sw_valid[g]                 = r_sw_valid[g];
        end
    endgenerate

    // Walk lanes starting at r_rr; the first lane to claim a destination owns it.
    always_comb begin
        w_grant      = '0;
        w_claimed    = '0;
        w_any_denied = 1'b0;
        w_lane       = r_rr;
        for (int k = 0; k < c_LANES; k++) begin
            w_lane = r_rr + 2'(k);
            if (w_nonempty[w_lane]) begin
                if (!w_claimed[w_head_dest[w_lane]]) begin
                    w_grant[w_lane]                 = 1'b1;
                    w_claimed[w_head_dest[w_lane]] = 1'b1;
                end else begin
                    w_any_denied = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr           <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (|w_grant) begin
                r_rr <= r_rr + 1'b1;
            end
            if (w_any_denied && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_banyan_ingress_sched.sv
// ============================================================================
//  Module   : tb_banyan_ingress_sched
//  Purpose  : Queue-based reference model with per-cycle output comparison
//             plus directed scenarios for banyan_ingress_sched.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_banyan_ingress_sched;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [7:0]  in_dest;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] sw_data;
    logic [7:0]  sw_addr;
    logic [3:0]  sw_valid;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    banyan_ingress_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_dest      (in_dest),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sw_data      (sw_data),
        .sw_addr      (sw_addr),
        .sw_valid     (sw_valid),
        .conflict_cnt (conflict_cnt)
    );

    // Reference model: one queue of {dest, data} per lane
    logic [9:0]  mq [4][$];
    logic [1:0]  m_rr;
    logic [3:0]  m_valid;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] v, input logic [7:0] d,
                              input logic [31:0] dt);
        bit   claimed [4];
        bit   granted [4];
        int   sz [4];
        bit   any_g;
        bit   any_d;
        logic [9:0] w;
        if (r) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_rr = 0; m_valid = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        end else begin
            any_g = 0;
            any_d = 0;
            for (int i = 0; i < 4; i++) begin
                claimed[i] = 0;
                granted[i] = 0;
                sz[i]      = mq[i].size();
            end
            for (int k = 0; k < 4; k++) begin
                int l;
                l = (int'(m_rr) + k) % 4;
                if (sz[l] > 0) begin
                    if (!claimed[mq[l][0][9:8]]) begin
                        claimed[mq[l][0][9:8]] = 1;
                        granted[l] = 1;
                        any_g = 1;
                    end else begin
                        any_d = 1;
                    end
                end
            end
            for (int l = 0; l < 4; l++) begin
                m_valid[l] = granted[l];
                if (granted[l]) begin
                    w = mq[l].pop_front();
                    m_addr[2*l +: 2] = w[9:8];
                    m_data[8*l +: 8] = w[7:0];
                end
                if (v[l] && sz[l] < DEPTH) mq[l].push_back({d[2*l +: 2], dt[8*l +: 8]});
            end
            if (any_g) m_rr = m_rr + 2'd1;
            if (any_d && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    function automatic logic [3:0] exp_ready();
        logic [3:0] rdy;
        for (int l = 0; l < 4; l++) rdy[l] = !rst && (mq[l].size() < DEPTH);
        return rdy;
    endfunction

    // Compare process: every edge, advance the model then check all outputs
    always @(posedge clk) begin
        model_step(rst, in_valid, in_dest, in_data);
        #1;
        chk("sw_valid", {28'd0, sw_valid}, {28'd0, m_valid});
        chk("sw_addr", {24'd0, sw_addr}, {24'd0, m_addr});
        chk("sw_data", sw_data, m_data);
        chk("conflict_cnt", {16'd0, conflict_cnt}, {16'd0, m_cnt});
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_ready()});
    end

    task automatic step(input logic r, input logic [3:0] v, input logic [7:0] d,
                        input logic [31:0] dt);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_dest  = d;
        in_data  = dt;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int   seq;
        bit   saw_full;
        rst      = 1'b1;
        in_valid = '0;
        in_dest  = '0;
        in_data  = '0;

        // Reset state
        repeat (3) step(1, 4'h0, 8'h00, 32'h0);
        chk("reset_sw_valid", {28'd0, sw_valid}, 32'h0);
        chk("reset_cnt", {16'd0, conflict_cnt}, 32'h0);
        chk("reset_ready", {28'd0, in_ready}, 32'h0);
        step(0, 4'h0, 8'h00, 32'h0);
        chk("ready_after_reset", {28'd0, in_ready}, 32'hF);

        // Permutation: dests 3,2,1,0 on lanes 0..3
        step(0, 4'hF, 8'h1B, 32'hA3A2A1A0);
        chk("perm_no_bypass", {28'd0, sw_valid}, 32'h0);
        step(0, 4'h0, 8'h00, 32'h0);
        chk("perm_valid", {28'd0, sw_valid}, 32'hF);
        chk("perm_addr", {24'd0, sw_addr}, 32'h1B);
        chk("perm_data", sw_data, 32'hA3A2A1A0);
        chk("perm_cnt", {16'd0, conflict_cnt}, 32'h0);

        // Full clash on dest 2 starting from rr = 0
        step(1, 4'h0, 8'h00, 32'h0);
        step(0, 4'hF, 8'hAA, 32'h13121110);
        for (int c = 0; c < 4; c++) begin
            step(0, 4'h0, 8'h00, 32'h0);
            chk("clash_valid", {28'd0, sw_valid}, 32'(1 << c));
            chk("clash_data", {24'd0, sw_data[8*c +: 8]}, 32'h10 + 32'(c));
            chk("clash_cnt", {16'd0, conflict_cnt}, (c < 3) ? 32'(c + 1) : 32'd3);
        end

        // Backpressure: lanes 0 and 1 fight for dest 1, lane 1 fills up
        step(1, 4'h0, 8'h00, 32'h0);
        seq = 1;
        saw_full = 0;
        for (int n = 0; n < 14; n++) begin
            int pre;
            pre = mq[1].size();
            step(0, 4'b0011, 8'b0000_0101, {16'h0, 8'(seq), 8'(8'h80 + n)});
            if (pre < DEPTH) seq++;
            if (mq[1].size() == DEPTH) begin
                saw_full = 1;
                chk("bp_ready1_full", {31'd0, in_ready[1]}, 32'h0);
            end
        end
        chk("bp_reached_full", {31'd0, saw_full}, 32'h1);
        repeat (12) step(0, 4'h0, 8'h00, 32'h0);

        // Reset with cells queued on every lane
        for (int n = 0; n < 6; n++) step(0, 4'hF, 8'h00, $urandom);
        step(1, 4'h0, 8'h00, 32'h0);
        chk("midrst_valid", {28'd0, sw_valid}, 32'h0);
        chk("midrst_ready", {28'd0, in_ready}, 32'h0);
        for (int n = 0; n < 6; n++) begin
            step(0, 4'h0, 8'h00, 32'h0);
            chk("no_stale", {28'd0, sw_valid}, 32'h0);
        end

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0), 4'($urandom), 8'($urandom), $urandom);
        end

        // Saturation of the conflict counter
        step(1, 4'h0, 8'h00, 32'h0);
        for (int n = 0; n < 70000; n++) step(0, 4'b0011, 8'h00, $urandom);
        chk("sat_cnt", {16'd0, conflict_cnt}, 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
